// File: rtl/wb_ctrl_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_ctrl_fifo
// Description : Captures N-bit ADC control samples into a FIFO. The FIFO is
//               drained by a CPU through a 16-byte register window on a
//               simple Wishbone-style bus. One DATA read pops up to four
//               samples. A level interrupt is raised when four or more
//               samples are waiting.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_ctrl_fifo #(
    parameter int          N         = 7,
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0002_0000
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         s_valid,
    input  logic [N-1:0] s_data,
    input  logic [29:0]  adr,
    input  logic [31:0]  dat,
    input  logic [3:0]   sel,
    input  logic         we,
    input  logic         cyc,
    output logic [31:0]  rdt,
    output logic         ack,
    output logic         irq
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int         c_AW         = $clog2(DEPTH);  // pointer width
    localparam int         c_CW         = c_AW + 1;       // count 0..DEPTH
    localparam logic [1:0] c_OFF_DATA   = 2'd0;           // 0x0
    localparam logic [1:0] c_OFF_STATUS = 2'd1;           // 0x4
    localparam logic [1:0] c_OFF_CTRL   = 2'd2;           // 0x8

    // Bus handshake: one ack per cycle request, even when cyc is held.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,   // waiting for a hit
        S_ACK  = 2'd1,   // ack is high this cycle
        S_HOLD = 2'd2    // access done, waiting for the master to drop cyc
    } bus_state_t;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [N-1:0]    r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_overflow;
    logic            r_irq;
    logic [31:0]     r_rdt;
    bus_state_t      r_state;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    bus_state_t      w_state_next;
    logic            w_hit;
    logic            w_access;        // the single edge where the access acts
    logic [1:0]      w_off;
    logic            w_pop_rd;
    logic            w_ctrl_wr;
    logic            w_flush;
    logic            w_ovf_clr;
    logic [2:0]      w_k;             // samples popped this cycle (0..4)
    logic [c_CW-1:0] w_count_after_pop;
    logic            w_push_ok;
    logic            w_push_drop;
    logic            w_empty;
    logic [31:0]     w_data_word;
    logic [31:0]     w_status_word;
    logic [31:0]     w_rd_value;
    logic            w_unused_bits;

    // Address decode: the window is 16 bytes, i.e. four word registers.
    assign w_hit = cyc && (adr[29:2] == BASE_ADDR[31:4]);
    assign w_off = adr[1:0];

    // Only CTRL bit0/bit1 under byte lane 0 carry meaning.
    assign w_unused_bits = ^{dat[31:2], sel[3:1]};

    // ------------------------------------------------------------------
    // Bus handshake FSM
    // ------------------------------------------------------------------
    // State register for the bus handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; an access is performed on the IDLE->ACK transition.
    always_comb begin
        w_state_next = r_state;
        w_access     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    w_state_next = S_ACK;
                    w_access     = 1'b1;
                end
            end
            S_ACK: begin
                w_state_next = cyc ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                if (!cyc) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign ack = (r_state == S_ACK);
    assign rdt = r_rdt;
    assign irq = r_irq;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    assign w_pop_rd  = w_access && !we && (w_off == c_OFF_DATA);
    assign w_ctrl_wr = w_access &&  we && (w_off == c_OFF_CTRL) && sel[0];
    assign w_flush   = w_ctrl_wr && dat[0];
    assign w_ovf_clr = w_ctrl_wr && dat[1];

    // A DATA read takes min(count, 4) samples.
    assign w_k = !w_pop_rd                    ? 3'd0 :
                 (r_count >= c_CW'(4))        ? 3'd4 :
                                                r_count[2:0];

    // The pop is credited before the push, so a full FIFO accepts a
    // sample on the same edge that a DATA read frees space.
    assign w_count_after_pop = r_count - c_CW'(w_k);
    assign w_push_ok   = s_valid && !w_flush && (w_count_after_pop < c_CW'(DEPTH));
    assign w_push_drop = s_valid && !w_flush && !w_push_ok;

    assign w_empty = (r_count == '0);

    // ------------------------------------------------------------------
    // Read data assembly: byte i holds the i-th oldest sample tagged with
    // bit 7 set, or zero when fewer than i+1 samples are queued.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        logic [c_AW-1:0] w_ptr;
        assign w_ptr = r_rd_ptr + c_AW'(gi);
        assign w_data_word[8*gi +: 8] = (r_count > c_CW'(gi)) ?
                                        (8'h80 | 8'(r_mem[w_ptr])) : 8'h00;
    end

    assign w_status_word = {13'd0, r_irq, w_empty, r_overflow, 16'(r_count)};

    // Register mux; writes, CTRL reads and the 0xC slot all read as zero.
    always_comb begin
        w_rd_value = 32'd0;
        if (!we) begin
            case (w_off)
                c_OFF_DATA:   w_rd_value = w_data_word;
                c_OFF_STATUS: w_rd_value = w_status_word;
                default:      w_rd_value = 32'd0;
            endcase
        end
    end

    // Read data is captured on the access edge and cleared otherwise, so it
    // is only non-zero while ack is high.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdt <= 32'd0;
        end else if (w_access) begin
            r_rdt <= w_rd_value;
        end else begin
            r_rdt <= 32'd0;
        end
    end

    // ------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------
    // Pointers and count: flush overrides both pop and push.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + c_AW'(w_k);
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_count <= w_count_after_pop + c_CW'(w_push_ok);
        end
    end

    // Sample storage; stale entries are harmless because pointers gate them.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= s_data;
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_overflow <= 1'b0;
        end else if (w_push_drop) begin
            r_overflow <= 1'b1;
        end else if (w_ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    // Interrupt level follows the count one cycle later.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (r_count >= c_CW'(4));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_ctrl_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_ctrl_fifo
// Description : Self-checking bench for wb_ctrl_fifo. It uses directed
//               register vectors, hand-built corner sequences and randomized
//               traffic. The random traffic is compared against a queue-based
//               model of the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_ctrl_fifo;

    localparam int          c_N     = 7;
    localparam int          c_DEPTH = 64;
    localparam logic [31:0] c_BASE  = 32'h0002_0000;
    localparam logic [27:0] c_WIN   = c_BASE[31:4];

    logic         clk;
    logic         resetn;
    logic         s_valid;
    logic [6:0]   s_data;
    logic [29:0]  adr;
    logic [31:0]  dat;
    logic [3:0]   sel;
    logic         we;
    logic         cyc;
    logic [31:0]  rdt;
    logic         ack;
    logic         irq;

    wb_ctrl_fifo #(
        .N         (c_N),
        .DEPTH     (c_DEPTH),
        .BASE_ADDR (c_BASE)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .s_valid (s_valid),
        .s_data  (s_data),
        .adr     (adr),
        .dat     (dat),
        .sel     (sel),
        .we      (we),
        .cyc     (cyc),
        .rdt     (rdt),
        .ack     (ack),
        .irq     (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of samples plus the flags seen by the CPU.
    // ------------------------------------------------------------------
    logic [6:0]  q[$];
    logic        m_ovf  = 1'b0;
    logic        m_irq  = 1'b0;
    logic        m_ack  = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_rdt  = 32'd0;
    logic        rnd_sv = 1'b0;

    task automatic model_step();
        logic        hit, acc, flush, clr, set, irq_n;
        int          k;
        logic [31:0] word;
        if (!resetn) begin
            q.delete();
            m_ovf = 0; m_irq = 0; m_ack = 0; m_done = 0; m_rdt = 0;
            return;
        end
        hit   = cyc && (adr[29:2] == c_WIN);
        acc   = hit && !m_ack && !m_done;
        k     = 0; flush = 0; clr = 0; set = 0; word = 0;
        if (acc) begin
            if (!we && adr[1:0] == 2'd0) begin
                k = (q.size() < 4) ? q.size() : 4;
                for (int i = 0; i < k; i++) word[8*i +: 8] = 8'h80 | 8'(q[i]);
            end else if (!we && adr[1:0] == 2'd1) begin
                word = {13'd0, m_irq, q.size() == 0, m_ovf, 16'(q.size())};
            end else if (we && adr[1:0] == 2'd2 && sel[0]) begin
                flush = dat[0];
                clr   = dat[1];
            end
        end
        irq_n = (q.size() >= 4);
        repeat (k) void'(q.pop_front());
        if (flush) q.delete();
        else if (s_valid) begin
            if (q.size() < c_DEPTH) q.push_back(s_data);
            else set = 1;
        end
        m_ovf  = set ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_done = cyc && (m_ack || m_done);
        m_ack  = acc;
        m_rdt  = word;
        m_irq  = irq_n;
    endtask

    // One clock: advance the model on the edge, compare just after it.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model_ack", {31'd0, ack}, {31'd0, m_ack});
        check("model_rdt", rdt, m_rdt);
        check("model_irq", {31'd0, irq}, {31'd0, m_irq});
        if (rnd_sv) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = 7'($urandom);
        end
    endtask

    function automatic logic [29:0] reg_adr(input logic [1:0] off);
        return {c_WIN, off};
    endfunction

    // Single bus transfer, bounded to four cycles waiting for ack.
    task automatic bus(input logic w, input logic [29:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic pv,
                       output logic [31:0] rd, output logic got);
        cyc = 1; we = w; adr = a; dat = d; sel = s; got = 0; rd = '0;
        if (!rnd_sv) begin s_valid = pv; s_data = 7'h55; end
        for (int i = 0; i < 4 && !got; i++) begin
            tick();
            if (!rnd_sv) s_valid = 0;
            if (ack === 1'b1) begin got = 1; rd = rdt; end
        end
        cyc = 0; we = 0; dat = 0; sel = 0;
        tick();
    endtask

    task automatic reg_chk(input string nm, input logic w, input logic [1:0] off,
                           input logic [31:0] d, input logic pv, input logic [31:0] exp);
        logic [31:0] rd;
        logic        got;
        bus(w, reg_adr(off), d, 4'hF, pv, rd, got);
        check({nm, "_ack"}, {31'd0, got}, 32'd1);
        check(nm, rd, exp);
    endtask

    task automatic push(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            s_valid = 1; s_data = 7'(base + i);
            tick();
        end
        s_valid = 0;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  off;
        logic [31:0] wdat;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t        tbl[11];
    logic [31:0] rd;
    logic        got;
    logic [4:0]  pat;
    int          nack;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        resetn = 0; s_valid = 1; s_data = 7'h11; cyc = 1; adr = reg_adr(2'd0);
        we = 0; dat = 0; sel = 4'hF;

        // Reset: activity on every input is ignored.
        repeat (3) tick();
        check("reset_ack", {31'd0, ack}, 32'd0);
        check("reset_rdt", rdt, 32'd0);
        resetn = 1; cyc = 0; s_valid = 0;
        tick();
        reg_chk("reset_status", 0, 2'd1, 0, 0, 32'h0002_0000);

        // Register vectors after six samples are queued.
        tbl[0]  = '{0, 2'd0, 32'h0,        32'h8483_8281, "data_first4"};
        tbl[1]  = '{0, 2'd1, 32'h0,        32'h0000_0002, "status_cnt2"};
        tbl[2]  = '{0, 2'd0, 32'h0,        32'h0000_8685, "data_partial"};
        tbl[3]  = '{0, 2'd1, 32'h0,        32'h0002_0000, "status_empty"};
        tbl[4]  = '{0, 2'd0, 32'h0,        32'h0000_0000, "data_none"};
        tbl[5]  = '{0, 2'd2, 32'h0,        32'h0000_0000, "ctrl_read"};
        tbl[6]  = '{0, 2'd3, 32'h0,        32'h0000_0000, "resv_read"};
        tbl[7]  = '{1, 2'd0, 32'hFFFF_FFFF, 32'h0000_0000, "data_write"};
        tbl[8]  = '{1, 2'd1, 32'hFFFF_FFFF, 32'h0000_0000, "status_write"};
        tbl[9]  = '{1, 2'd3, 32'hFFFF_FFFF, 32'h0000_0000, "resv_write"};
        tbl[10] = '{0, 2'd1, 32'h0,        32'h0002_0000, "status_after"};
        push(6, 1);
        tick(); tick();
        check("irq_six", {31'd0, irq}, 32'd1);
        for (int i = 0; i < 11; i++)
            reg_chk(tbl[i].name, tbl[i].we, tbl[i].off, tbl[i].wdat, 0, tbl[i].exp);

        // Two samples, including all-ones and all-zeros.
        push(1, 7'h7F); push(1, 0);
        reg_chk("data_7f_00", 0, 2'd0, 0, 0, 32'h0000_80FF);
        reg_chk("status_7f_00", 0, 2'd1, 0, 0, 32'h0002_0000);

        // Overflow: the 65th sample is lost, clear and drain.
        push(c_DEPTH + 1, 0);
        reg_chk("ovf_status", 0, 2'd1, 0, 0, 32'h0005_0040);
        reg_chk("ovf_clear", 1, 2'd2, 32'h2, 0, 32'h0);
        reg_chk("ovf_cleared_status", 0, 2'd1, 0, 0, 32'h0004_0040);
        for (int i = 0; i < 15; i++) bus(0, reg_adr(2'd0), 0, 4'hF, 0, rd, got);
        reg_chk("ovf_last_data", 0, 2'd0, 0, 0, 32'hBFBE_BDBC);
        reg_chk("ovf_drained", 0, 2'd1, 0, 0, 32'h0002_0000);

        // Flush; CTRL with sel[0]=0 is ignored.
        push(5, 9);
        bus(1, reg_adr(2'd2), 32'h1, 4'hE, 0, rd, got);
        reg_chk("flush_nosel", 0, 2'd1, 0, 0, 32'h0004_0005);
        reg_chk("flush_wr", 1, 2'd2, 32'h1, 0, 32'h0);
        reg_chk("flush_status", 0, 2'd1, 0, 0, 32'h0002_0000);

        // Full FIFO: a push on the DATA ack edge is accepted.
        push(c_DEPTH, 0);
        reg_chk("full_pop_push", 0, 2'd0, 0, 1, 32'h8382_8180);
        reg_chk("full_pop_status", 0, 2'd1, 0, 0, 32'h0004_003D);
        // Flush and push together: sample dropped, no overflow.
        reg_chk("flush_push", 1, 2'd2, 32'h1, 1, 32'h0);
        reg_chk("flush_push_status", 0, 2'd1, 0, 0, 32'h0002_0000);
        // Overflow set and clear together: set wins.
        push(c_DEPTH, 0);
        reg_chk("setclr_wr", 1, 2'd2, 32'h2, 1, 32'h0);
        reg_chk("setclr_status", 0, 2'd1, 0, 0, 32'h0005_0040);
        reg_chk("flush_clr", 1, 2'd2, 32'h3, 0, 32'h0);
        reg_chk("flush_clr_status", 0, 2'd1, 0, 0, 32'h0002_0000);

        // Held cyc: a single ack in the second cycle.
        cyc = 1; we = 0; adr = reg_adr(2'd1); sel = 4'hF; pat = '0;
        for (int i = 0; i < 5; i++) begin tick(); pat[i] = ack; end
        cyc = 0; tick();
        check("held_cyc_pattern", {27'd0, pat}, 32'h0000_0001);
        // Outside the window: never acked.
        cyc = 1; adr = {c_WIN + 28'd1, 2'd1}; nack = 0;
        for (int i = 0; i < 5; i++) begin tick(); if (ack) nack++; end
        cyc = 0; tick();
        check("miss_no_ack", nack, 0);

        // Reset in the middle of a DATA access with eight samples queued.
        push(8, 32);
        tick(); tick();
        cyc = 1; we = 0; adr = reg_adr(2'd0);
        #2 resetn = 0;
        #1;
        check("rst_async_irq", {31'd0, irq}, 32'd0);
        tick();
        check("rst_abort_ack", {31'd0, ack}, 32'd0);
        tick();
        resetn = 1; cyc = 0;
        tick();
        reg_chk("rst_status", 0, 2'd1, 0, 0, 32'h0002_0000);

        // Randomized traffic against the model.
        rnd_sv = 1;
        for (int n = 0; n < 600; n++) begin
            int          r;
            logic        w;
            logic [1:0]  off;
            logic [29:0] a;
            logic [31:0] d;
            r = $urandom_range(0, 9);
            if (r < 3) tick();
            else begin
                w   = (r == 9);
                off = (r < 6) ? 2'd0 : ((r < 8) ? 2'd1 : 2'($urandom_range(0, 3)));
                a   = reg_adr(off);
                if ($urandom_range(0, 9) == 0) a = 30'($urandom);
                d   = $urandom;
                if ($urandom_range(0, 3) != 0) d[0] = 1'b0;
                bus(w, a, d, 4'($urandom), 0, rd, got);
            end
        end
        rnd_sv = 0; s_valid = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
